seg_data_drive: RTL and testbench
=================================

SEG_DATA_DRIVE -- requirements
Module: seg_data_drive

Interface
REQ-001 SHALL have parameter BLANK_CYCLES, default 16, meaning the number of segment-blank cycles after each digit-select change (range 1..255).
REQ-002 SHALL have port clk  input  1  system clock, 100 MHz.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port led_en  input  8  digit select from the scanner, active-low, one-hot-low; bit i selects digit i.
REQ-005 SHALL have port data_in  input  32  display value; nibble data_in[4i+3:4i] is the hex value for digit i.
REQ-006 SHALL have port dp_in  input  8  decimal-point request, active-high; bit i is for digit i.
REQ-007 SHALL have port data_load  input  1  one-cycle request to capture data_in and dp_in.
REQ-008 SHALL have port load_ack  output  1  one-cycle pulse when captured data becomes the displayed data.
REQ-009 SHALL have port led_ca  output  8  segment drive, active-low: bits 0..6 = segments a..g, bit 7 = DP.
REQ-010 SHALL have port scan_err  output  1  high while led_en is not exactly one-hot-low.

Function
REQ-011 SHALL register all outputs, with a latency of 1 clk from an led_en or display-data change to led_ca.
REQ-012 SHALL decode the hex glyphs 0-F with DP off as follows: 0=0xC0, 1=0xF9, 2=0xA4, 3=0xB0, 4=0x99, 5=0x92, 6=0x82, 7=0xF8, 8=0x80, 9=0x90, A=0x88, b=0x83, C=0xC6, d=0xA1, E=0x86, F=0x8E.
REQ-013 SHALL clear led_ca[7] (DP lit) when the active digit's committed dp bit is 1.
REQ-014 SHALL keep a registered copy en_q of led_en and detect a change when led_en != en_q.
REQ-015 SHALL, on a change detected in cycle t, drive led_ca=0xFF from edge t+1 for exactly BLANK_CYCLES cycles, then show the glyph.
REQ-016 SHALL restart the blank count from BLANK_CYCLES if a further change occurs during blanking.
REQ-017 SHALL, when data_load=1, capture data_in and dp_in into a pending register and set the pending flag.
REQ-018 SHALL let the latest load win: a second data_load while a load is pending overwrites the pending value, and only one load_ack follows.
REQ-019 SHALL commit pending data to the displayed registers on a frame event: a change into led_en==8'hFE.
REQ-020 SHALL pulse load_ack for 1 cycle on commit, in the cycle after the frame event, and clear the pending flag.
REQ-021 SHALL, when data_load and a frame event occur in the same cycle, commit data_in and dp_in directly and pulse load_ack.
REQ-022 SHALL, when led_en has zero or more than one low bit, assert scan_err (registered, 1-cycle latency), force led_ca=0xFF, and leave pending and commit state unaffected.
REQ-023 SHALL treat led_en==8'hFF as a change source for blanking, but SHALL NOT treat it as a frame event.

Reset
REQ-024 SHALL, while rst=1 at a clk edge, set: displayed data=0, dp=0, pending data and flag=0, en_q=8'hFF, blank counter=0, led_ca=8'hFF, load_ack=0, scan_err=0.
REQ-025 SHALL drop a pending load and any blanking in progress on a mid-operation reset, with no load_ack issued.

Configuration
REQ-026 SHALL, with macro LEAD_ZERO_BLANK_EN defined, blank segments a..g of every digit above the most significant nonzero committed nibble; digit 0 is always shown, and DP still follows dp.
REQ-027 SHALL, without LEAD_ZERO_BLANK_EN, show all eight digits with no suppression logic synthesized.

Verification
REQ-028 SHALL cover: reset, then led_en=8'hFE with data 0 -> led_ca=0xFF for 16 cycles, then 0xC0.
REQ-029 SHALL cover: data_load with data_in=32'h0000_00A1 and dp_in=8'h02, then a scan rotating FE->FD -> load_ack 1 cycle after the FE entry; digit0=0xF9; digit1=0x08 (A with DP lit).
REQ-030 SHALL cover: two data_loads (0x11111111, then 0x22222222) before a frame event -> a single load_ack, and the displayed digits are 0xA4.
REQ-031 SHALL cover: led_en=8'hFC -> scan_err=1 and led_ca=0xFF next cycle; then led_en=8'hFB -> scan_err=0 and blanking of 16 cycles applies.
REQ-032 SHALL cover: with LEAD_ZERO_BLANK_EN and data 32'h0000_0305 -> digits 3..7 read 0xFF, digit 2=0xB0, digit 1=0xC0, digit 0=0x92; without the macro, digit 7=0xC0.
REQ-033 SHALL cover: rst asserted mid-blank with a load pending -> led_ca=0xFF, and no load_ack after the next frame event.

Source files
------------

// File: rtl/seg_data_drive.sv
// Purpose : hex seven-segment driver with per-digit DP, anti-ghost blanking and frame-aligned data commit.
// Latency : 1 clk from led_en or displayed-data change to led_ca; load_ack 1 clk after the frame event.
// Backpres: none; data_load is always accepted, latest load wins. Optional LEAD_ZERO_BLANK_EN suppresses leading zeros.
module seg_data_drive #(
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  led_en,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic        data_load,
    output logic        load_ack,
    output logic [7:0]  led_ca,
    output logic        scan_err
);

    // The counter holds the number of blank cycles still owed after the
    // cycle that detected the change (that cycle blanks on its own).
    localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES - 1);

    // Scan tracking
    logic [7:0]  en_q;
    logic [7:0]  blank_cnt;
    logic        en_chg;
    logic        frame_evt;
    logic        en_onehot;
    logic [7:0]  en_act;
    logic        blank_now;

    // Data path
    logic [31:0] disp_dat;
    logic [7:0]  disp_dp;
    logic [31:0] pend_dat;
    logic [7:0]  pend_dp;
    logic        pend_vld;

    // Next-state for the load/commit path
    logic [31:0] disp_dat_nxt;
    logic [7:0]  disp_dp_nxt;
    logic [31:0] pend_dat_nxt;
    logic [7:0]  pend_dp_nxt;
    logic        pend_vld_nxt;
    logic        load_ack_nxt;

    // Glyph path
    logic [2:0]  dig_idx;
    logic [3:0]  dig_nib;
    logic [6:0]  seg_raw;
    logic [6:0]  seg_vis;
    logic [7:0]  glyph;

    // Change, frame and scan-validity detection on the live digit select
    always_comb begin
        en_act    = ~led_en;
        en_chg    = (led_en != en_q);
        frame_evt = en_chg && (led_en == 8'hFE);
        en_onehot = (en_act != 8'd0) && ((en_act & (en_act - 8'd1)) == 8'd0);
        blank_now = en_chg || (blank_cnt != 8'd0);
    end

    // Previous digit select and the blank countdown; a new change restarts it
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q      <= 8'hFF;
            blank_cnt <= 8'd0;
        end else begin
            en_q <= led_en;
            if (en_chg) begin
                blank_cnt <= BLANK_LOAD;
            end else if (blank_cnt != 8'd0) begin
                blank_cnt <= blank_cnt - 8'd1;
            end
        end
    end

    // Pending capture and frame-aligned commit; a load coinciding with the frame bypasses pending
    always_comb begin
        disp_dat_nxt = disp_dat;
        disp_dp_nxt  = disp_dp;
        pend_dat_nxt = pend_dat;
        pend_dp_nxt  = pend_dp;
        pend_vld_nxt = pend_vld;
        load_ack_nxt = 1'b0;
        if (frame_evt && data_load) begin
            disp_dat_nxt = data_in;
            disp_dp_nxt  = dp_in;
            pend_vld_nxt = 1'b0;
            load_ack_nxt = 1'b1;
        end else if (frame_evt && pend_vld) begin
            disp_dat_nxt = pend_dat;
            disp_dp_nxt  = pend_dp;
            pend_vld_nxt = 1'b0;
            load_ack_nxt = 1'b1;
        end else if (data_load) begin
            pend_dat_nxt = data_in;
            pend_dp_nxt  = dp_in;
            pend_vld_nxt = 1'b1;
        end
    end

    // Load/commit state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_dat <= 32'd0;
            disp_dp  <= 8'd0;
            pend_dat <= 32'd0;
            pend_dp  <= 8'd0;
            pend_vld <= 1'b0;
            load_ack <= 1'b0;
        end else begin
            disp_dat <= disp_dat_nxt;
            disp_dp  <= disp_dp_nxt;
            pend_dat <= pend_dat_nxt;
            pend_dp  <= pend_dp_nxt;
            pend_vld <= pend_vld_nxt;
            load_ack <= load_ack_nxt;
        end
    end

    // Active digit index from the low bit of led_en (only meaningful when one-hot-low)
    always_comb begin
        dig_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!led_en[i]) begin
                dig_idx = 3'(i);
            end
        end
        dig_nib = disp_dat[{dig_idx, 2'b00} +: 4];
    end

    // Hex to active-low segments a..g
    always_comb begin
        seg_raw = 7'h7F;
        case (dig_nib)
            4'h0: seg_raw = 7'h40;
            4'h1: seg_raw = 7'h79;
            4'h2: seg_raw = 7'h24;
            4'h3: seg_raw = 7'h30;
            4'h4: seg_raw = 7'h19;
            4'h5: seg_raw = 7'h12;
            4'h6: seg_raw = 7'h02;
            4'h7: seg_raw = 7'h78;
            4'h8: seg_raw = 7'h00;
            4'h9: seg_raw = 7'h10;
            4'hA: seg_raw = 7'h08;
            4'hB: seg_raw = 7'h03;
            4'hC: seg_raw = 7'h46;
            4'hD: seg_raw = 7'h21;
            4'hE: seg_raw = 7'h06;
            4'hF: seg_raw = 7'h0E;
            default: seg_raw = 7'h7F;
        endcase
    end

`ifdef LEAD_ZERO_BLANK_EN
    logic [2:0] msd_idx;

    // Digits above the most significant nonzero nibble go dark; digit 0 always shows
    always_comb begin
        msd_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (disp_dat[4*i +: 4] != 4'd0) begin
                msd_idx = 3'(i);
            end
        end
        seg_vis = (dig_idx > msd_idx) ? 7'h7F : seg_raw;
    end
`else
    // All digits shown as decoded
    always_comb begin
        seg_vis = seg_raw;
    end
`endif

    // DP is lit (low) when the committed dp bit of the active digit is set
    always_comb begin
        glyph = {~disp_dp[dig_idx], seg_vis};
    end

    // Registered outputs: blank on scan error or during the post-change window
    always_ff @(posedge clk) begin
        if (rst) begin
            led_ca   <= 8'hFF;
            scan_err <= 1'b0;
        end else begin
            scan_err <= !en_onehot;
            led_ca   <= (!en_onehot || blank_now) ? 8'hFF : glyph;
        end
    end

endmodule

// File: tb/tb_seg_data_drive.sv
// Bench for seg_data_drive: directed scenarios plus a randomized scan/load phase.
// Every cycle is predicted by a timestamp-based reference model; directed points add constant checks.
// Set LEAD_ZERO_BLANK_EN at compile time to exercise the suppression build.
module tb_seg_data_drive;

    localparam int BLANK = 16;

    logic        clk;
    logic        rst;
    logic [7:0]  led_en;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic        data_load;
    logic        load_ack;
    logic [7:0]  led_ca;
    logic        scan_err;

    int tests = 0;
    int fails = 0;
    int ack_cnt = 0;

    // Reference model state
    int          m_cyc  = 0;
    int          m_last = -1000000;
    logic [7:0]  m_prev = 8'hFF;
    logic [31:0] m_disp = 32'd0;
    logic [7:0]  m_dp   = 8'd0;
    logic [31:0] m_pend = 32'd0;
    logic [7:0]  m_pdp  = 8'd0;
    logic        m_pflag = 1'b0;

    logic [7:0] lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [7:0] dig_exp [8];

    seg_data_drive #(.BLANK_CYCLES(BLANK)) dut (
        .clk       (clk),
        .rst       (rst),
        .led_en    (led_en),
        .data_in   (data_in),
        .dp_in     (dp_in),
        .data_load (data_load),
        .load_ack  (load_ack),
        .led_ca    (led_ca),
        .scan_err  (scan_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s (cycle %0d): got %h expected %h", tag, m_cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_glyph(input int idx);
        logic [7:0] g;
        int msd;
        g = lut[m_disp[idx*4 +: 4]];
        msd = 0;
        for (int i = 1; i < 8; i++) if (m_disp[i*4 +: 4] != 4'd0) msd = i;
`ifdef LEAD_ZERO_BLANK_EN
        if (idx > msd) g = 8'hFF;
`endif
        if (m_dp[idx]) g[7] = 1'b0;
        return g;
    endfunction

    // Predict the next edge from the current inputs, advance one clock, compare.
    task automatic tick();
        logic [7:0] e_ca;
        logic       e_ack;
        logic       e_err;
        logic       chg;
        int         lows;
        int         idx;
        e_ca = 8'hFF; e_ack = 1'b0; e_err = 1'b0;
        if (rst) begin
            m_prev = 8'hFF; m_last = -1000000;
            m_disp = 32'd0; m_dp = 8'd0;
            m_pend = 32'd0; m_pdp = 8'd0; m_pflag = 1'b0;
        end else begin
            chg = (led_en != m_prev);
            if (chg) m_last = m_cyc;
            lows = 0; idx = 0;
            for (int i = 0; i < 8; i++) if (!led_en[i]) begin lows++; idx = i; end
            e_err = (lows != 1);
            if (e_err || (m_cyc + 1 - m_last) <= BLANK) e_ca = 8'hFF;
            else e_ca = exp_glyph(idx);
            if (data_load) begin m_pend = data_in; m_pdp = dp_in; m_pflag = 1'b1; end
            if (chg && led_en == 8'hFE && m_pflag) begin
                m_disp = m_pend; m_dp = m_pdp; m_pflag = 1'b0; e_ack = 1'b1;
            end
            m_prev = led_en;
        end
        m_cyc++;
        @(posedge clk);
        #1;
        if (load_ack === 1'b1) ack_cnt++;
        check("model_led_ca", {24'd0, led_ca}, {24'd0, e_ca});
        check("model_load_ack", {31'd0, load_ack}, {31'd0, e_ack});
        check("model_scan_err", {31'd0, scan_err}, {31'd0, e_err});
    endtask

    task automatic hold(input logic [7:0] en, input int n);
        led_en = en;
        data_load = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(input logic [31:0] d, input logic [7:0] p);
        data_in = d; dp_in = p; data_load = 1'b1;
        tick();
        data_load = 1'b0;
    endtask

    initial begin
        int a0;
        int r;
        int n;
        logic [7:0] en;
        logic [7:0] one;

        rst = 1'b1; led_en = 8'hFF; data_in = 32'd0; dp_in = 8'd0; data_load = 1'b0;
        tick(); tick(); tick();
        check("reset_led_ca", {24'd0, led_ca}, 32'h0000_00FF);
        check("reset_load_ack", {31'd0, load_ack}, 32'd0);
        check("reset_scan_err", {31'd0, scan_err}, 32'd0);

        // First digit after reset: 16 blank cycles then '0'
        rst = 1'b0;
        hold(8'hFE, BLANK);
        check("first_blank_last", {24'd0, led_ca}, 32'h0000_00FF);
        hold(8'hFE, 1);
        check("first_glyph_0", {24'd0, led_ca}, 32'h0000_00C0);

        // Load A1 with DP on digit 1, commit on the FE entry
        load(32'h0000_00A1, 8'h02);
        hold(8'hFD, BLANK + 1);
        check("pre_commit_digit1", {24'd0, led_ca}, 32'h0000_00C0);
        a0 = ack_cnt;
        hold(8'hFE, 1);
        check("commit_ack_pulse", {31'd0, load_ack}, 32'd1);
        hold(8'hFE, BLANK);
        check("digit0_is_1", {24'd0, led_ca}, 32'h0000_00F9);
        check("single_ack_a1", ack_cnt, a0 + 1);
        hold(8'hFD, BLANK + 1);
        check("digit1_A_dp", {24'd0, led_ca}, 32'h0000_0008);

        // Two loads before a frame: latest wins, one ack
        a0 = ack_cnt;
        load(32'h1111_1111, 8'h00);
        hold(8'hFD, 1);
        load(32'h2222_2222, 8'h00);
        hold(8'hFD, BLANK + 1);
        hold(8'hFE, BLANK + 1);
        check("latest_wins_d0", {24'd0, led_ca}, 32'h0000_00A4);
        check("latest_wins_one_ack", ack_cnt, a0 + 1);
        hold(8'hFD, BLANK + 1);
        check("latest_wins_d1", {24'd0, led_ca}, 32'h0000_00A4);

        // Invalid select, then recovery with fresh blanking
        hold(8'hFC, 1);
        check("bad_scan_err", {31'd0, scan_err}, 32'd1);
        check("bad_scan_ca", {24'd0, led_ca}, 32'h0000_00FF);
        hold(8'hFB, 1);
        check("recover_err", {31'd0, scan_err}, 32'd0);
        hold(8'hFB, BLANK - 1);
        check("recover_blank_end", {24'd0, led_ca}, 32'h0000_00FF);
        hold(8'hFB, 1);
        check("recover_glyph", {24'd0, led_ca}, 32'h0000_00A4);

        // Leading-zero behaviour with 0x305
        load(32'h0000_0305, 8'h00);
        hold(8'hFD, 2);
        hold(8'hFE, BLANK + 1);
`ifdef LEAD_ZERO_BLANK_EN
        dig_exp = '{8'h92, 8'hC0, 8'hB0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`else
        dig_exp = '{8'h92, 8'hC0, 8'hB0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif
        for (int i = 0; i < 8; i++) begin
            one = 8'h01;
            hold(~(one << i), BLANK + 1);
            check($sformatf("lzb_digit%0d", i), {24'd0, led_ca}, {24'd0, dig_exp[i]});
        end

        // Reset mid-blank with a load pending
        load(32'h1234_5678, 8'hFF);
        hold(8'hFD, 3);
        rst = 1'b1;
        tick();
        check("midrst_ca", {24'd0, led_ca}, 32'h0000_00FF);
        check("midrst_ack", {31'd0, load_ack}, 32'd0);
        rst = 1'b0;
        a0 = ack_cnt;
        hold(8'hFE, BLANK + 4);
        check("midrst_no_ack", ack_cnt, a0);
        check("midrst_disp_cleared", {24'd0, led_ca}, 32'h0000_00C0);

        // Randomized scan/load/reset traffic against the model
        for (int k = 0; k < 150; k++) begin
            r = int'($urandom_range(0, 99));
            one = 8'h01;
            if (r < 25) en = 8'hFE;
            else if (r < 80) en = ~(one << $urandom_range(0, 7));
            else if (r < 92) en = 8'($urandom);
            else en = 8'hFF;
            n = int'($urandom_range(1, 24));
            for (int j = 0; j < n; j++) begin
                led_en    = en;
                data_load = ($urandom_range(0, 7) == 0);
                data_in   = $urandom >> (4 * $urandom_range(0, 7));
                dp_in     = 8'($urandom);
                rst       = ($urandom_range(0, 299) == 0);
                tick();
            end
        end
        rst = 1'b0;
        data_load = 1'b0;
        hold(8'hFE, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
